// File: rtl/insn_word_encoder.sv
// Packs instruction field bundles into 32-bit words and streams them into imem via a small FIFO.
// Optional illegal-instruction filtering is enabled by defining ILLEGAL_CHECK_EN.
module insn_word_encoder #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_fmt,
    input  logic [4:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_shamt,
    input  logic [4:0]        in_aluop,
    input  logic [16:0]       in_imm,
    input  logic [26:0]       in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_data,
    input  logic              imem_stall,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [ADDR_W:0]    cnt_q, cnt_d;
    logic [ADDR_W:0]    accepted_q, accepted_d;
    logic [ADDR_W-1:0]  last_addr_q;
    logic [31:0]        last_data_q;

    logic [31:0]        fifo_mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [PTR_W:0]     fill_q, fill_d;
    logic               full, empty;

    logic [31:0]        enc_word;
    logic               accept, push, pop;

    always_comb begin
        enc_word = 32'd0;
        case (in_fmt)
            2'b00:   enc_word = {in_opcode, in_rd, in_rs, in_rt, in_shamt, in_aluop, 2'b00};
            2'b01:   enc_word = {in_opcode, in_rd, in_rs, in_imm};
            2'b10:   enc_word = {in_opcode, in_target};
            default: enc_word = {in_opcode, in_rd, 22'd0};
        endcase
    end

    assign full     = (fill_q == (PTR_W + 1)'(DEPTH));
    assign empty    = (fill_q == '0);
    assign in_ready = (state_q == StLoad) && !full && (accepted_q < cnt_q);
    assign imem_we  = (state_q == StLoad) && !empty && !imem_stall;
    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign accept   = in_valid && in_ready;
    assign pop      = imem_we;

    // Outputs show the head while writing and otherwise hold the last written beat.
    assign imem_addr = imem_we ? wr_addr_q : last_addr_q;
    assign imem_data = imem_we ? fifo_mem[rd_ptr_q] : last_data_q;

`ifdef ILLEGAL_CHECK_EN
    logic legal;
    logic err_q;

    always_comb begin
        legal = 1'b0;
        if (in_fmt == 2'b00) begin
            legal = (in_opcode == 5'd0) && ((in_aluop == 5'd0) || (in_aluop == 5'd1));
        end else if (in_fmt == 2'b01) begin
            legal = (in_opcode == 5'd5) || (in_opcode == 5'd7) || (in_opcode == 5'd8);
        end
    end

    // Illegal bundles still complete the handshake and count, but are dropped.
    assign push = accept && legal;
    assign err  = err_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if ((state_q == StIdle) && start) begin
            err_q <= 1'b0;
        end else if (accept && !legal) begin
            err_q <= 1'b1;
        end
    end
`else
    assign push = accept;
    assign err  = 1'b0;
`endif

    assign fill_d = fill_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);

    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        cnt_d      = cnt_q;
        accepted_d = accepted_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    wr_addr_d  = base_addr;
                    cnt_d      = count;
                    accepted_d = '0;
                    state_d    = StLoad;
                end
            end
            StLoad: begin
                if (accept) begin
                    accepted_d = accepted_q + 1'b1;
                end
                if (pop) begin
                    wr_addr_d = wr_addr_q + 1'b1;
                end
                // Evaluated on next-state values so cnt = 0 exits on the first LOAD cycle.
                if ((accepted_d == cnt_q) && (fill_d == '0)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            wr_addr_q   <= '0;
            cnt_q       <= '0;
            accepted_q  <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            last_addr_q <= '0;
            last_data_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            cnt_q      <= cnt_d;
            accepted_q <= accepted_d;
            fill_q     <= fill_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q    <= rd_ptr_q + PTR_W'(1);
                last_addr_q <= wr_addr_q;
                last_data_q <= fifo_mem[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= enc_word;
        end
    end

endmodule

// File: tb/tb_insn_word_encoder.sv
// Directed bench for insn_word_encoder: a scoreboard queue holds expected imem writes.
// Also exercises the ILLEGAL_CHECK_EN build when that macro is defined.
module tb_insn_word_encoder;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DEPTH  = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   count = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        in_fmt = '0;
    logic [4:0]        in_opcode = '0;
    logic [4:0]        in_rd = '0;
    logic [4:0]        in_rs = '0;
    logic [4:0]        in_rt = '0;
    logic [4:0]        in_shamt = '0;
    logic [4:0]        in_aluop = '0;
    logic [16:0]       in_imm = '0;
    logic [26:0]       in_target = '0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              imem_stall = 1'b0;
    logic              busy;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_we_cyc = -100;
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [ADDR_W+31:0] sb[$];

    insn_word_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
        .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_shamt(in_shamt),
        .in_aluop(in_aluop), .in_imm(in_imm), .in_target(in_target),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_data(imem_data),
        .imem_stall(imem_stall), .busy(busy), .done(done), .err(err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [1:0] f, input logic [4:0] op,
                                        input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] sh,
                                        input logic [4:0] alu, input logic [16:0] imm,
                                        input logic [26:0] tgt);
        case (f)
            2'b00:   return {op, rd, rs, rt, sh, alu, 2'b00};
            2'b01:   return {op, rd, rs, imm};
            2'b10:   return {op, tgt};
            default: return {op, rd, 22'd0};
        endcase
    endfunction

    // Write monitor: every imem write must match the oldest expected entry.
    always @(negedge clock) begin
        if (!reset && imem_we) begin
            logic [ADDR_W+31:0] e;
            chk("write_during_stall", imem_stall, 0);
            if (sb.size() == 0) begin
                chk("unexpected_write_addr", imem_addr, 'hDEAD);
            end else begin
                e = sb.pop_front();
                chk("write_addr", imem_addr, e[ADDR_W+31:32]);
                chk("write_data", imem_data, e[31:0]);
            end
            last_we_cyc = cyc;
        end
    end

    task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] c);
        start = 1'b1;
        base_addr = b;
        count = c;
        exp_addr = b;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [1:0] f, input logic [4:0] op, input logic [4:0] rd,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] sh,
                        input logic [4:0] alu, input logic [16:0] imm, input logic [26:0] tgt,
                        input logic [31:0] exp, input bit push);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_fmt = f; in_opcode = op; in_rd = rd; in_rs = rs; in_rt = rt;
        in_shamt = sh; in_aluop = alu; in_imm = imm; in_target = tgt;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clock);
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                if (push) begin
                    sb.push_back({exp_addr, exp});
                    exp_addr = exp_addr + 1'b1;
                end
            end
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        chk("send_accepted", ok, 1);
    endtask

    task automatic send_i(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs,
                          input logic [16:0] imm);
        send(2'b01, op, rd, rs, 5'd0, 5'd0, 5'd0, imm, 27'd0,
             enc(2'b01, op, rd, rs, 5'd0, 5'd0, 5'd0, imm, 27'd0), 1'b1);
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge clock);
            if (done === 1'b1) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, seen, 1);
        chk({tag, "_done_after_last_write"}, 64'(cyc - last_we_cyc), 1);
        chk({tag, "_all_written"}, sb.size(), 0);
        @(negedge clock);
        chk({tag, "_done_busy_after"}, {done, busy}, 2'b00);
        @(posedge clock); #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        chk("reset_outputs", {in_ready, imem_we, done, busy, err, imem_addr, imem_data}, 0);
        @(posedge clock); #1;
        reset = 1'b0;

        // Basic session with literal expected words
        do_start(12'h010, 3);
        @(negedge clock);
        chk("busy_after_start", busy, 1);
        @(posedge clock); #1;
        send(2'b00, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 5'd0, 17'd0, 27'd0, 32'h00443000, 1'b1);
        send(2'b01, 5'd5, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 17'd5, 27'd0, 32'h29000005, 1'b1);
        send(2'b01, 5'd7, 5'd5, 5'd6, 5'd0, 5'd0, 5'd0, 17'h1FFFF, 27'd0, 32'h394DFFFF, 1'b1);
        wait_done("basic");

        // Stall: FIFO fills, ready drops, start ignored while busy
        imem_stall = 1'b1;
        do_start(12'h020, 6);
        for (int i = 0; i < 4; i++) begin
            send_i((i % 3 == 0) ? 5'd5 : (i % 3 == 1) ? 5'd7 : 5'd8,
                   5'($urandom), 5'($urandom), 17'($urandom));
        end
        @(negedge clock);
        chk("full_blocks_ready", in_ready, 0);
        @(posedge clock); #1;
        start = 1'b1; base_addr = 12'h555; count = 1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        @(negedge clock);
        chk("stall_still_full", {in_ready, busy}, 2'b01);
        @(posedge clock); #1;
        imem_stall = 1'b0;
        send_i(5'd8, 5'd31, 5'd17, 17'h0ABCD);
        send_i(5'd5, 5'd9, 5'd3, 17'h10001);
        wait_done("stall");

        // Zero-count session
        do_start(12'h000, 0);
        @(negedge clock);
        chk("cnt0_load_cycle", {done, busy}, 2'b01);
        @(negedge clock);
        chk("cnt0_done_cycle", {done, busy}, 2'b11);
        @(negedge clock);
        chk("cnt0_idle_after", {done, busy}, 2'b00);
        @(posedge clock); #1;

        // Address wrap-around
        do_start(12'hFFE, 3);
        send_i(5'd7, 5'd1, 5'd1, 17'd1);
        send_i(5'd7, 5'd2, 5'd2, 17'd2);
        send_i(5'd7, 5'd3, 5'd3, 17'd3);
        wait_done("wrap");

        // Reset mid-session discards buffered words
        imem_stall = 1'b1;
        do_start(12'h200, 4);
        send_i(5'd5, 5'd1, 5'd2, 17'h00123);
        send_i(5'd5, 5'd3, 5'd4, 17'h00456);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("midreset_outputs", {in_ready, imem_we, done, busy, err, imem_addr, imem_data}, 0);
        sb.delete();
        imem_stall = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        chk("post_reset_idle", {busy, imem_we, in_ready}, 3'b000);
        @(posedge clock); #1;
        do_start(12'h100, 1);
        send_i(5'd8, 5'd6, 5'd7, 17'h0F0F0);
        wait_done("after_reset");

`ifdef ILLEGAL_CHECK_EN
        // Illegal R bundle is counted but dropped; err is sticky until next start
        do_start(12'h300, 2);
        send(2'b00, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 5'd3, 17'd0, 27'd0, 32'd0, 1'b0);
        send(2'b01, 5'd5, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 17'd5, 27'd0, 32'h29000005, 1'b1);
        wait_done("illegal");
        chk("err_sticky", err, 1);
        do_start(12'h000, 0);
        @(negedge clock);
        chk("err_cleared_by_start", err, 0);
        repeat (3) @(posedge clock);
        #1;
`else
        // Remaining formats with don't-care fields driven non-zero
        do_start(12'h040, 3);
        send(2'b00, 5'd0, 5'd9, 5'd10, 5'd11, 5'd31, 5'd21, 17'h1FFFF, 27'h7FFFFFF,
             enc(2'b00, 5'd0, 5'd9, 5'd10, 5'd11, 5'd31, 5'd21, 17'h1FFFF, 27'h7FFFFFF), 1'b1);
        send(2'b10, 5'd19, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 17'h1FFFF, 27'h5A5A5A5,
             enc(2'b10, 5'd19, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 17'h1FFFF, 27'h5A5A5A5), 1'b1);
        send(2'b11, 5'd30, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 17'h1FFFF, 27'h7FFFFFF,
             enc(2'b11, 5'd30, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 17'h1FFFF, 27'h7FFFFFF), 1'b1);
        wait_done("formats");
        chk("err_tied_low", err, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
